bp_be_regfile_wb_arbiter: RTL and testbench

- Shares the single regfile write port (rd_w_v/rd_addr/rd_data) among num_req_p writeback sources: int pipe, long-latency mul/div, and memory fill.
- Uses fixed priority plus anti-starvation aging.
- Registers the granted write one cycle before it reaches the regfile.
- Keeps a per-register busy scoreboard so issue logic can stall on pending long-latency destinations.

---
 rtl/bp_be_regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_bp_be_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bp_be_regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port: fixed priority with
// anti-starvation aging, a registered write stage, and a per-register busy scoreboard.
module bp_be_regfile_wb_arbiter #(
  parameter int num_req_p        = 3,
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5,
  parameter int starve_limit_p   = 8,
  localparam int rf_els_lp       = 2**reg_addr_width_p
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p*reg_addr_width_p-1:0]  req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]      req_data_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  input  logic                                   score_v_i,
  input  logic [reg_addr_width_p-1:0]            score_addr_i,
  output logic [rf_els_lp-1:0]                   busy_o,
  output logic                                   rd_w_v_o,
  output logic [reg_addr_width_p-1:0]            rd_addr_o,
  output logic [data_width_p-1:0]                rd_data_o
);

  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);

  logic [cnt_w_lp-1:0]         wait_cnt_q [num_req_p];
  logic [cnt_w_lp-1:0]         wait_cnt_d [num_req_p];
  logic [num_req_p-1:0]        starving;
  logic [num_req_p-1:0]        grant;
  logic                        found;
  logic [reg_addr_width_p-1:0] win_addr;
  logic [data_width_p-1:0]     win_data;

  logic                        rd_w_v_q, rd_w_v_d;
  logic [reg_addr_width_p-1:0] rd_addr_q, rd_addr_d;
  logic [data_width_p-1:0]     rd_data_q, rd_data_d;
  logic [rf_els_lp-1:0]        busy_q, busy_d;

  // Starving requesters override plain priority; lowest index wins within each class.
  always_comb begin
    starving = '0;
    grant    = '0;
    found    = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < num_req_p; i++) begin
      starving[i] = req_v_i[i] && (wait_cnt_q[i] == cnt_w_lp'(starve_limit_p));
    end
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && ((|starving) ? starving[i] : req_v_i[i])) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!reset_n_i) begin
      grant = '0;
    end
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) begin
        win_addr = req_addr_i[i*reg_addr_width_p +: reg_addr_width_p];
        win_data = req_data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (!req_v_i[i] || grant[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != cnt_w_lp'(starve_limit_p)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + cnt_w_lp'(1);
      end
    end
  end

  // x0 writes are consumed but never reach the regfile.
  always_comb begin
    rd_w_v_d  = (|grant) && (win_addr != '0);
    rd_addr_d = (|grant) ? win_addr : rd_addr_q;
    rd_data_d = (|grant) ? win_data : rd_data_q;
    busy_d    = busy_q;
    if (rd_w_v_q) begin
      busy_d[rd_addr_q] = 1'b0;
    end
    if (score_v_i && (score_addr_i != '0)) begin
      busy_d[score_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_w_v_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
      for (int i = 0; i < num_req_p; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rd_w_v_q  <= rd_w_v_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      for (int i = 0; i < num_req_p; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign req_ready_o = grant;
  assign rd_w_v_o    = rd_w_v_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_bp_be_regfile_wb_arbiter.sv
// Directed bench for bp_be_regfile_wb_arbiter: vector table plus starvation and reset sequences.
module tb_bp_be_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int RF = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_v;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              score_v;
  logic [AW-1:0]     score_addr;
  logic [RF-1:0]     busy;
  logic              rd_w_v;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bp_be_regfile_wb_arbiter #(
    .num_req_p(NR), .data_width_p(DW), .reg_addr_width_p(AW), .starve_limit_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .score_v_i(score_v), .score_addr_i(score_addr), .busy_o(busy),
    .rd_w_v_o(rd_w_v), .rd_addr_o(rd_addr), .rd_data_o(rd_data)
  );

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [63:0] d0, d1, d2;
    logic        sv;
    logic [4:0]  sa;
    logic [2:0]  ready;
    logic        wv;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [31:0] busy;
    logic        chk_ad;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic sv, input logic [4:0] sa);
    req_v      = v;
    req_addr   = {a2, a1, a0};
    req_data   = {d2, d1, d0};
    score_v    = sv;
    score_addr = sa;
  endtask

  // Check combinational grant mid-cycle, then move to just after the next edge.
  task automatic step_ready(input string nm, input logic [2:0] exp);
    @(negedge clk);
    chk(nm, 64'(req_ready), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  // req2 held valid against a continuously valid req0; req2 must win on cycle n_lose+1.
  task automatic starve_round(input string nm, input int n_lose);
    for (int k = 0; k < n_lose; k++) begin
      drive(3'b101, 5'(k + 1), 5'd0, 5'd10, 64'(k), 64'h0, 64'hA2, 1'b0, 5'd0);
      step_ready({nm, "_lose"}, 3'b001);
    end
    drive(3'b101, 5'd20, 5'd0, 5'd10, 64'h20, 64'h0, 64'hA2, 1'b0, 5'd0);
    step_ready({nm, "_win"}, 3'b100);
    chk({nm, "_wv"}, 64'(rd_w_v), 64'd1);
    chk({nm, "_wa"}, 64'(rd_addr), 64'd10);
    chk({nm, "_wd"}, rd_data, 64'hA2);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 5'd0, 5'd5, 5'd0, 64'h0, 64'hDEAD, 64'h0, 1'b0, 5'd0,
                 3'b010, 1'b1, 5'd5, 64'hDEAD, 32'h0, 1'b1};
    vecs[1]  = '{3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0,
                 3'b000, 1'b0, 5'd5, 64'hDEAD, 32'h0, 1'b1};
    vecs[2]  = '{3'b101, 5'd3, 5'd0, 5'd9, 64'h33, 64'h0, 64'h99, 1'b0, 5'd0,
                 3'b001, 1'b1, 5'd3, 64'h33, 32'h0, 1'b1};
    vecs[3]  = '{3'b100, 5'd0, 5'd0, 5'd9, 64'h0, 64'h0, 64'h99, 1'b0, 5'd0,
                 3'b100, 1'b1, 5'd9, 64'h99, 32'h0, 1'b1};
    vecs[4]  = '{3'b110, 5'd0, 5'd4, 5'd6, 64'h0, 64'h44, 64'h66, 1'b0, 5'd0,
                 3'b010, 1'b1, 5'd4, 64'h44, 32'h0, 1'b1};
    vecs[5]  = '{3'b100, 5'd0, 5'd0, 5'd6, 64'h0, 64'h0, 64'h66, 1'b0, 5'd0,
                 3'b100, 1'b1, 5'd6, 64'h66, 32'h0, 1'b1};
    vecs[6]  = '{3'b010, 5'd0, 5'd0, 5'd0, 64'h0, 64'hFF, 64'h0, 1'b1, 5'd0,
                 3'b010, 1'b0, 5'd0, 64'h0, 32'h0, 1'b0};
    vecs[7]  = '{3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b1, 5'd7,
                 3'b000, 1'b0, 5'd0, 64'h0, 32'h80, 1'b0};
    vecs[8]  = '{3'b010, 5'd0, 5'd7, 5'd0, 64'h0, 64'h77, 64'h0, 1'b0, 5'd0,
                 3'b010, 1'b1, 5'd7, 64'h77, 32'h80, 1'b1};
    vecs[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0,
                 3'b000, 1'b0, 5'd7, 64'h77, 32'h0, 1'b1};
    vecs[10] = '{3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b1, 5'd7,
                 3'b000, 1'b0, 5'd7, 64'h77, 32'h80, 1'b1};
    vecs[11] = '{3'b010, 5'd0, 5'd7, 5'd0, 64'h0, 64'h78, 64'h0, 1'b0, 5'd0,
                 3'b010, 1'b1, 5'd7, 64'h78, 32'h80, 1'b1};
    vecs[12] = '{3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b1, 5'd7,
                 3'b000, 1'b0, 5'd7, 64'h78, 32'h80, 1'b1};
    vecs[13] = '{3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0,
                 3'b000, 1'b0, 5'd7, 64'h78, 32'h80, 1'b1};
    vecs[14] = '{3'b011, 5'd7, 5'd2, 5'd0, 64'h70, 64'h22, 64'h0, 1'b0, 5'd0,
                 3'b001, 1'b1, 5'd7, 64'h70, 32'h80, 1'b1};
    vecs[15] = '{3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0,
                 3'b000, 1'b0, 5'd7, 64'h70, 32'h0, 1'b1};

    // Reset held with all requesters valid.
    reset_n = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 1'b0, 5'd0);
    #1;
    step_ready("rst_ready0", 3'b000);
    step_ready("rst_ready1", 3'b000);
    chk("rst_wv", 64'(rd_w_v), 64'd0);
    chk("rst_wa", 64'(rd_addr), 64'd0);
    chk("rst_wd", rd_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    reset_n = 1'b1;
    step_ready("rel_ready", 3'b001);
    chk("rel_wv", 64'(rd_w_v), 64'd1);
    chk("rel_wa", 64'(rd_addr), 64'd1);
    chk("rel_wd", rd_data, 64'h11);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0);
    step_ready("idle_ready", 3'b000);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].a2,
            vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].sv, vecs[i].sa);
      step_ready($sformatf("vec%0d_ready", i), vecs[i].ready);
      chk($sformatf("vec%0d_wv", i), 64'(rd_w_v), 64'(vecs[i].wv));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
      if (vecs[i].chk_ad) begin
        chk($sformatf("vec%0d_wa", i), 64'(rd_addr), 64'(vecs[i].wa));
        chk($sformatf("vec%0d_wd", i), rd_data, vecs[i].wd);
      end
    end

    // Two back-to-back rounds: the second proves the counter cleared on grant.
    starve_round("starve1", 8);
    starve_round("starve2", 8);

    // Dropping valid mid-wait restarts the aging from zero.
    for (int k = 0; k < 5; k++) begin
      drive(3'b101, 5'd1, 5'd0, 5'd10, 64'h1, 64'h0, 64'hA2, 1'b0, 5'd0);
      step_ready("drop_pre", 3'b001);
    end
    drive(3'b001, 5'd1, 5'd0, 5'd10, 64'h1, 64'h0, 64'hA2, 1'b0, 5'd0);
    step_ready("drop_gap", 3'b001);
    starve_round("starve3", 8);

    // Reset mid-operation drops a granted write and the scoreboard.
    drive(3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b1, 5'd3);
    step_ready("pre_rst_ready", 3'b000);
    chk("pre_rst_busy", 64'(busy), 64'h8);
    drive(3'b010, 5'd0, 5'd12, 5'd0, 64'h0, 64'hC, 64'h0, 1'b0, 5'd0);
    reset_n = 1'b0;
    step_ready("mid_rst_ready", 3'b000);
    chk("mid_rst_wv", 64'(rd_w_v), 64'd0);
    chk("mid_rst_wa", 64'(rd_addr), 64'd0);
    chk("mid_rst_wd", rd_data, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    step_ready("post_rst_ready", 3'b010);
    chk("post_rst_wa", 64'(rd_addr), 64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
